// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: byte stream in, FIPS 180-4 padded 512-bit blocks out as
// 16 big-endian 32-bit words per block, with first/block-last/message-last markers.
module sha256_msg_padder #(
    parameter int unsigned LEN_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_keep,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_first,
    output logic        out_blk_last,
    output logic        out_msg_last,
    output logic        busy,
    output logic        len_ovf
);

    typedef enum logic [2:0] {StIdle, StData, StPad80, StZero, StLen, StDrain} state_e;

    state_e           state_q, state_d;
    logic [23:0]      shreg_q, shreg_d;
    logic [5:0]       pos_q, pos_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             spill_q, spill_d;
    logic [2:0]       len_idx_q, len_idx_d;
    logic             first_q, first_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_data_q, out_data_d;
    logic             out_first_q, out_first_d;
    logic             out_blk_last_q, out_blk_last_d;
    logic             out_msg_last_q, out_msg_last_d;

    logic        slot_free, word_end, can_adv, adv, in_ready_c, carry;
    logic [7:0]  byte_in;
    logic [63:0] len_bits;
    logic [7:0]  len_byte;

    assign slot_free = !out_valid_q || out_ready;
    assign word_end  = (pos_q[1:0] == 2'b11);
    assign can_adv   = !word_end || slot_free;
    assign len_bits  = 64'(cnt_q) << 3;
    // ~len_idx_q == 7 - len_idx_q: length bytes go out MSB first
    assign len_byte  = len_bits[{~len_idx_q, 3'b000} +: 8];

    always_comb begin
        state_d        = state_q;
        shreg_d        = shreg_q;
        pos_d          = pos_q;
        cnt_d          = cnt_q;
        ovf_d          = ovf_q;
        spill_d        = spill_q;
        len_idx_d      = len_idx_q;
        first_d        = first_q;
        out_valid_d    = out_valid_q && !out_ready;
        out_data_d     = out_data_q;
        out_first_d    = out_first_q;
        out_blk_last_d = out_blk_last_q;
        out_msg_last_d = out_msg_last_q;
        adv            = 1'b0;
        byte_in        = 8'h00;
        in_ready_c     = 1'b0;
        carry          = 1'b0;

        case (state_q)
            StIdle: begin
                in_ready_c = 1'b1;
                if (in_valid && (in_keep || in_last)) begin
                    first_d = 1'b1;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    if (in_keep) begin
                        adv     = 1'b1;
                        byte_in = in_data;
                        cnt_d   = LEN_W'(1);
                    end
                    state_d = in_last ? StPad80 : StData;
                end
            end
            StData: begin
                in_ready_c = can_adv;
                if (in_valid && can_adv) begin
                    if (in_keep) begin
                        adv              = 1'b1;
                        byte_in          = in_data;
                        {carry, cnt_d}   = {1'b0, cnt_q} + 1'b1;
                        if (carry) ovf_d = 1'b1;
                    end
                    if (in_last) state_d = StPad80;
                end
            end
            StPad80: begin
                byte_in = 8'h80;
                if (can_adv) begin
                    adv = 1'b1;
                    if (pos_q == 6'd55) begin
                        state_d   = StLen;
                        len_idx_d = '0;
                    end else begin
                        state_d = StZero;
                        // 0x80 landed past the length slot: fill out this block first
                        spill_d = (pos_q[5:3] == 3'b111) && (pos_q != 6'd63);
                    end
                end
            end
            StZero: begin
                if (can_adv) begin
                    adv = 1'b1;
                    if (pos_q == 6'd63) spill_d = 1'b0;
                    if (!spill_q && pos_q == 6'd55) begin
                        state_d   = StLen;
                        len_idx_d = '0;
                    end
                end
            end
            StLen: begin
                byte_in = len_byte;
                if (can_adv) begin
                    adv       = 1'b1;
                    len_idx_d = len_idx_q + 3'd1;
                    if (len_idx_q == 3'd7) state_d = StDrain;
                end
            end
            StDrain: begin
                if (out_valid_q && out_ready && out_msg_last_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (adv) begin
            shreg_d = {shreg_q[15:0], byte_in};
            pos_d   = pos_q + 6'd1;
            if (word_end) begin
                out_valid_d    = 1'b1;
                out_data_d     = {shreg_q, byte_in};
                out_first_d    = first_q;
                out_blk_last_d = (pos_q[5:2] == 4'hf);
                out_msg_last_d = (state_q == StLen) && (pos_q == 6'd63);
                first_d        = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            shreg_q        <= '0;
            pos_q          <= '0;
            cnt_q          <= '0;
            ovf_q          <= 1'b0;
            spill_q        <= 1'b0;
            len_idx_q      <= '0;
            first_q        <= 1'b0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_first_q    <= 1'b0;
            out_blk_last_q <= 1'b0;
            out_msg_last_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            shreg_q        <= shreg_d;
            pos_q          <= pos_d;
            cnt_q          <= cnt_d;
            ovf_q          <= ovf_d;
            spill_q        <= spill_d;
            len_idx_q      <= len_idx_d;
            first_q        <= first_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_first_q    <= out_first_d;
            out_blk_last_q <= out_blk_last_d;
            out_msg_last_q <= out_msg_last_d;
        end
    end

    assign in_ready     = in_ready_c && rst_n;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_first    = out_first_q;
    assign out_blk_last = out_blk_last_q;
    assign out_msg_last = out_msg_last_q;
    assign busy         = (state_q != StIdle);
    assign len_ovf      = ovf_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Scoreboard bench for sha256_msg_padder: stimulus pushes expected words, a
// negedge monitor pops and compares on each accepted output word.
module tb_sha256_msg_padder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        in_keep = 1'b0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_first;
    logic        out_blk_last;
    logic        out_msg_last;
    logic        busy;
    logic        len_ovf;

    int checks = 0;
    int errors = 0;
    logic [34:0] exp_q[$];
    logic mon_en = 1'b1;
    logic rand_mode = 1'b0;

    always #5 clk = ~clk;

    sha256_msg_padder #(.LEN_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_keep(in_keep), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_first(out_first), .out_blk_last(out_blk_last), .out_msg_last(out_msg_last),
        .busy(busy), .len_ovf(len_ovf)
    );

    task automatic check1(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] d, input logic f, input logic b, input logic m);
        exp_q.push_back({f, b, m, d});
    endtask

    // FIPS 180-4 padding of n copies of fill
    task automatic push_padded(input int n, input logic [7:0] fill);
        logic [7:0]  b[$];
        logic [63:0] bits;
        int nw;
        for (int i = 0; i < n; i++) b.push_back(fill);
        b.push_back(8'h80);
        while (b.size() % 64 != 56) b.push_back(8'h00);
        bits = 64'(n) * 64'd8;
        for (int i = 0; i < 8; i++) b.push_back(bits[63 - 8*i -: 8]);
        nw = b.size() / 4;
        for (int w = 0; w < nw; w++)
            push_word({b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]},
                      w == 0, (w % 16) == 15, w == nw - 1);
    endtask

    task automatic push_abc();
        push_word(32'h61626380, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) push_word(32'h0, 1'b0, 1'b0, 1'b0);
        push_word(32'h00000018, 1'b0, 1'b1, 1'b1);
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is taken
    task automatic send_beat(input logic [7:0] d, input logic k, input logic l);
        int t;
        bit done;
        in_valid = 1'b1; in_data = d; in_keep = k; in_last = l;
        t = 0; done = 0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) done = 1;
            @(posedge clk); #1;
            t++;
            if (!done && t > 2000) begin
                checks++; errors++;
                $display("FAIL beat_accept: in_ready never seen, got 0 expected 1");
                done = 1;
            end
        end
        in_valid = 1'b0; in_keep = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_abc();
        send_beat(8'h61, 1'b1, 1'b0);
        send_beat(8'h62, 1'b1, 1'b0);
        send_beat(8'h63, 1'b1, 1'b1);
    endtask

    task automatic send_fill(input int n, input logic [7:0] fill);
        for (int i = 0; i < n; i++) send_beat(fill, 1'b1, i == n - 1);
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy || out_valid) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check1({name, "_drain"}, 32'(exp_q.size()), 32'd0);
        check1({name, "_busy"}, {31'd0, busy}, 32'd0);
        check1({name, "_len_ovf"}, {31'd0, len_ovf}, 32'd0);
        @(posedge clk); #1;
    endtask

    // out_ready driver
    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = rand_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    // Monitor / scoreboard
    initial begin
        logic        held_v;
        logic [34:0] held;
        logic [34:0] got;
        logic [34:0] exp;
        held_v = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!mon_en || !rst_n) begin
                held_v = 1'b0;
            end else begin
                got = {out_first, out_blk_last, out_msg_last, out_data};
                if (held_v) begin
                    checks++;
                    if (!out_valid || got !== held) begin
                        errors++;
                        $display("FAIL stall_stable: got v=%b %h, expected v=1 %h",
                                 out_valid, got, held);
                    end
                end
                held_v = out_valid && !out_ready;
                held = got;
                if (out_valid && out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_word: got %h, expected no word", got);
                    end else begin
                        exp = exp_q.pop_front();
                        if (got !== exp) begin
                            errors++;
                            $display("FAIL word(first,blk,msg,data): got %h, expected %h",
                                     got, exp);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check1("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check1("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check1("rst_busy", {31'd0, busy}, 32'd0);
        check1("rst_flags", {29'd0, out_first, out_blk_last, out_msg_last}, 32'd0);
        check1("rst_len_ovf", {31'd0, len_ovf}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        push_abc();
        send_abc();
        wait_done("abc");

        push_word(32'h80000000, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) push_word(32'h0, 1'b0, i == 14, i == 14);
        send_beat(8'h00, 1'b0, 1'b1);
        wait_done("empty");

        push_padded(55, 8'h41);
        send_fill(55, 8'h41);
        wait_done("len55");

        push_padded(56, 8'h41);
        send_fill(56, 8'h41);
        wait_done("len56");

        push_padded(64, 8'h5a);
        send_fill(64, 8'h5a);
        wait_done("len64");

        rand_mode = 1'b1;
        push_abc();
        send_abc();
        wait_done("abc_rand");
        push_padded(61, 8'hc3);
        send_fill(61, 8'hc3);
        wait_done("len61_rand");
        rand_mode = 1'b0;
        @(posedge clk); #1;

        // Abandon a message mid-flight with a one-cycle reset
        mon_en = 1'b0;
        for (int i = 0; i < 20; i++) send_beat(8'h41, 1'b1, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check1("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        check1("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check1("mid_rst_out_data", out_data, 32'd0);
        check1("mid_rst_busy", {31'd0, busy}, 32'd0);
        check1("mid_rst_flags", {29'd0, out_first, out_blk_last, out_msg_last}, 32'd0);
        rst_n = 1'b1;
        exp_q.delete();
        mon_en = 1'b1;
        @(posedge clk); #1;
        push_abc();
        send_abc();
        wait_done("abc_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
